// File: rtl/design_exmpl_sched.sv
// Two-requester run scheduler: arbitrates req_i, launches one datapath run, waits for F to clear/set, acks.
// Build option: DESIGN_EXMPL_SCHED_RR_EN selects round-robin arbitration (default is fixed priority, req 0 first).
module design_exmpl_sched #(
  parameter int unsigned TIMEOUT = 20
) (
  input  logic       clk_i,
  input  logic       rst_b_i,
  input  logic [1:0] req_i,
  input  logic       F_i,
  input  logic       E_i,
  output logic       start_o,
  output logic [1:0] gnt_o,
  output logic [1:0] ack_o,
  output logic       err_o,
  output logic       res_E_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_CLR, RUN, DONE} state_e;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_e     state_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       start_q;
  logic [1:0] gnt_q;
  logic [1:0] ack_q;
  logic [1:0] mask_q;
  logic       err_q;
  logic       res_q;
  logic       busy_q;
  logic [1:0] elig;
  logic [1:0] win_d;
  logic       tmo;
`ifdef DESIGN_EXMPL_SCHED_RR_EN
  logic       ptr_q;
`endif

  // A requester acked last cycle sits out exactly one arbitration.
  always_comb begin
    elig  = req_i & ~mask_q;
    win_d = elig;
    if (elig == 2'b11) begin
`ifdef DESIGN_EXMPL_SCHED_RR_EN
      win_d = ptr_q ? 2'b10 : 2'b01;
`else
      win_d = 2'b01;
`endif
    end
    cnt_d = cnt_q + 8'd1;
    tmo   = (cnt_d == TMO);
  end

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      gnt_q   <= '0;
      ack_q   <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
      res_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef DESIGN_EXMPL_SCHED_RR_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      mask_q  <= ack_q;
      case (state_q)
        IDLE: begin
          if (|win_d) begin
            gnt_q   <= win_d;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= LAUNCH;
`ifdef DESIGN_EXMPL_SCHED_RR_EN
            ptr_q   <= win_d[0];
`endif
          end
        end
        LAUNCH: begin
          cnt_q   <= '0;
          state_q <= WAIT_CLR;
        end
        WAIT_CLR, RUN: begin
          cnt_q <= cnt_d;
          // Timeout overrides whatever F_i is doing this cycle.
          if (tmo) begin
            state_q <= DONE;
            ack_q   <= gnt_q;
            err_q   <= 1'b1;
            res_q   <= 1'b0;
          end else if (state_q == WAIT_CLR && !F_i) begin
            state_q <= RUN;
          end else if (state_q == RUN && F_i) begin
            state_q <= DONE;
            ack_q   <= gnt_q;
            res_q   <= E_i;
          end
        end
        DONE: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_o = start_q;
  assign gnt_o   = gnt_q;
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign res_E_o = res_q;
  assign busy_o  = busy_q;

endmodule
